// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared defaults and sizing helper for the operand latch bank
package latch_pkg;

    localparam int DEFAULT_WIDTH           = 4;
    localparam int DEFAULT_CHANNELS        = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

    // Counter runs 0..cycles-1, so $clog2(cycles) bits always suffice.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer plus stable-level debouncer with press strobe
module button_debouncer
    import latch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_n,
    output logic press
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          stable;
    logic [CW-1:0] count;
    logic          at_limit;

    // Strobe is high in the cycle whose closing edge drops the stable level,
    // so the consumer loads on exactly that edge.
    always_comb begin
        at_limit = (sync_2 != stable) && (count == CNT_MAX);
        press    = at_limit && !sync_2;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            stable <= 1'b1;
            count  <= '0;
        end else begin
            sync_1 <= button_n;
            sync_2 <= sync_1;
            if (sync_2 == stable) begin
                count <= '0;
            end else if (at_limit) begin
                stable <= sync_2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_latch_bank.sv
// rtl/operand_latch_bank.sv - debounced per-channel operand capture with valid/ack handoff
module operand_latch_bank
    import latch_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int CHANNELS        = DEFAULT_CHANNELS,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       save_n,
    input  logic [WIDTH-1:0]          data_input,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       loaded,
    output logic                      operands_valid,
    input  logic                      operands_ack
);

    logic [CHANNELS-1:0] press;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .clk      (clk),
            .reset_n  (reset_n),
            .button_n (save_n[g]),
            .press    (press[g])
        );
    end

    // While valid is high the set is frozen: presses are dropped, only ack acts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q              <= '0;
            loaded         <= '0;
            operands_valid <= 1'b0;
        end else if (operands_valid) begin
            if (operands_ack) begin
                operands_valid <= 1'b0;
                loaded         <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (press[i]) begin
                    q[i*WIDTH +: WIDTH] <= data_input;
                    loaded[i]           <= 1'b1;
                end
            end
            if (&loaded) begin
                operands_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_latch_bank.sv
// tb/tb_operand_latch_bank.sv - directed self-checking bench for operand_latch_bank
module tb_operand_latch_bank;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] save_n;
    logic [3:0] data_input;
    logic [7:0] q;
    logic [1:0] loaded;
    logic       operands_valid;
    logic       operands_ack;

    int total = 0;
    int bad   = 0;

    operand_latch_bank #(
        .WIDTH(4),
        .CHANNELS(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .save_n         (save_n),
        .data_input     (data_input),
        .q              (q),
        .loaded         (loaded),
        .operands_valid (operands_valid),
        .operands_ack   (operands_ack)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; save_n = 2'b11; data_input = 4'h0; operands_ack = 1'b0;
        step(2);
        reset_n = 1'b1;
        total++;
        if ({q, loaded, operands_valid} !== {8'h00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_state got q=%h loaded=%b valid=%b want q=00 loaded=00 valid=0", q, loaded, operands_valid);
        end
    endtask

    task automatic test_channel0_load();
        data_input = 4'h5; save_n = 2'b10;
        step(5);
        total++;
        if (loaded !== 2'b00) begin
            bad++;
            $display("FAIL ch0_early got loaded=%b want 00", loaded);
        end
        step(1);
        total++;
        if ({q, loaded, operands_valid} !== {8'h05, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL ch0_load got q=%h loaded=%b valid=%b want q=05 loaded=01 valid=0", q, loaded, operands_valid);
        end
        step(4);
        save_n = 2'b11;
        step(8);
        total++;
        if ({q, loaded, operands_valid} !== {8'h05, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL ch0_hold got q=%h loaded=%b valid=%b want q=05 loaded=01 valid=0", q, loaded, operands_valid);
        end
    endtask

    task automatic test_complete_set();
        data_input = 4'hA; save_n = 2'b01;
        step(6);
        total++;
        if ({q, loaded, operands_valid} !== {8'hA5, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL ch1_load got q=%h loaded=%b valid=%b want q=a5 loaded=11 valid=0", q, loaded, operands_valid);
        end
        step(1);
        total++;
        if (operands_valid !== 1'b1) begin
            bad++;
            $display("FAIL valid_rise got valid=%b want 1", operands_valid);
        end
        save_n = 2'b11;
        step(8);
    endtask

    task automatic test_locked();
        data_input = 4'hF; save_n = 2'b10;
        step(8);
        total++;
        if ({q, loaded, operands_valid} !== {8'hA5, 2'b11, 1'b1}) begin
            bad++;
            $display("FAIL locked got q=%h loaded=%b valid=%b want q=a5 loaded=11 valid=1", q, loaded, operands_valid);
        end
        save_n = 2'b11;
        step(8);
    endtask

    task automatic test_handshake();
        operands_ack = 1'b1;
        step(1);
        operands_ack = 1'b0;
        total++;
        if ({q, loaded, operands_valid} !== {8'hA5, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL handshake got q=%h loaded=%b valid=%b want q=a5 loaded=00 valid=0", q, loaded, operands_valid);
        end
        operands_ack = 1'b1;
        step(2);
        operands_ack = 1'b0;
        total++;
        if ({loaded, operands_valid} !== {2'b00, 1'b0}) begin
            bad++;
            $display("FAIL idle_ack got loaded=%b valid=%b want loaded=00 valid=0", loaded, operands_valid);
        end
    endtask

    task automatic test_glitch();
        data_input = 4'hC; save_n = 2'b10;
        step(3);
        save_n = 2'b11;
        step(8);
        total++;
        if ({q, loaded, operands_valid} !== {8'hA5, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL glitch got q=%h loaded=%b valid=%b want q=a5 loaded=00 valid=0", q, loaded, operands_valid);
        end
    endtask

    task automatic test_simultaneous();
        data_input = 4'h3; save_n = 2'b00;
        step(5);
        total++;
        if (loaded !== 2'b00) begin
            bad++;
            $display("FAIL both_early got loaded=%b want 00", loaded);
        end
        step(1);
        total++;
        if ({q, loaded, operands_valid} !== {8'h33, 2'b11, 1'b0}) begin
            bad++;
            $display("FAIL both_load got q=%h loaded=%b valid=%b want q=33 loaded=11 valid=0", q, loaded, operands_valid);
        end
        step(1);
        total++;
        if (operands_valid !== 1'b1) begin
            bad++;
            $display("FAIL both_valid got valid=%b want 1", operands_valid);
        end
        save_n = 2'b11;
        step(8);
    endtask

    task automatic test_ack_collision();
        data_input = 4'h7; save_n = 2'b01;
        step(5);
        operands_ack = 1'b1;
        step(1);
        operands_ack = 1'b0;
        total++;
        if ({q, loaded, operands_valid} !== {8'h33, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL ack_collision got q=%h loaded=%b valid=%b want q=33 loaded=00 valid=0", q, loaded, operands_valid);
        end
        step(2);
        save_n = 2'b11;
        step(8);
    endtask

    task automatic test_reset_mid_debounce();
        data_input = 4'h9; save_n = 2'b10;
        step(2);
        reset_n = 1'b0;
        #1;
        total++;
        if ({q, loaded, operands_valid} !== {8'h00, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL async_reset got q=%h loaded=%b valid=%b want q=00 loaded=00 valid=0", q, loaded, operands_valid);
        end
        step(2);
        reset_n = 1'b1;
        step(5);
        total++;
        if (loaded !== 2'b00) begin
            bad++;
            $display("FAIL rst_abort got loaded=%b want 00", loaded);
        end
        step(1);
        total++;
        if ({q, loaded, operands_valid} !== {8'h09, 2'b01, 1'b0}) begin
            bad++;
            $display("FAIL rst_reload got q=%h loaded=%b valid=%b want q=09 loaded=01 valid=0", q, loaded, operands_valid);
        end
        step(3);
        total++;
        if (operands_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_partial_valid got valid=%b want 0", operands_valid);
        end
        save_n = 2'b11;
    endtask

    initial begin
        test_reset();
        test_channel0_load();
        test_complete_set();
        test_locked();
        test_handshake();
        test_glitch();
        test_simultaneous();
        test_ack_collision();
        test_reset_mid_debounce();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
